// File: rtl/iir_pkg.sv
// Shared definitions for the IIR feed sequencer: default widths, the
// sequencer state encoding and a helper for sizing the latency counter.
package iir_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 24;
    localparam int GAP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Width of a down-counter that has to hold values 0 .. lat-1.
    function automatic int lat_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/iir_feed_fifo.sv
// Sample buffer in front of the filter sequencer. DEPTH entries of DW bits,
// power-of-two depth so the pointers wrap on their own. The head entry is
// presented combinationally; push is refused when full and pop when empty,
// and a synchronous clear empties the buffer with priority over both.
module iir_feed_fifo
    import iir_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o && !clear_i;
    assign pop_ok_s  = pop_i && !empty_o && !clear_i;

    // Next pointer and occupancy values; clear wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok_s && !pop_ok_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_ok_s && !push_ok_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage, written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/iir_feed_ctrl.sv
// Sequencer in front of the shared IIR filter. Buffers samples, issues one
// at a time to the filter as a single-cycle f_data_en pulse, waits the fixed
// filter latency, captures the result and holds it on a valid/ready output.
// A programmable idle gap, loaded when a result is accepted, spaces issues.
// Only one sample is ever in flight. clear restarts the sequencer and drops
// anything queued or in flight; the filter itself is left untouched.
module iir_feed_ctrl
    import iir_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int RW       = RW_DEF,
    parameter int DEPTH    = 4,
    parameter int FILT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [GAP_W-1:0] gap_cfg,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             f_data_en,
    output logic [DW-1:0]    f_data,
    input  logic [RW-1:0]    f_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_data,
    output logic             busy
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LAT_W = lat_width(FILT_LAT);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(FILT_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               f_data_en_q, f_data_en_d;
    logic [DW-1:0]      f_data_q, f_data_d;
    logic               out_valid_q, out_valid_d;
    logic [RW-1:0]      out_data_q, out_data_d;

    logic               push_s;
    logic               pop_s;
    logic [DW-1:0]      head_s;
    logic [CW-1:0]      count_s;
    logic               full_s;
    logic               empty_s;

    assign in_ready  = !full_s;
    assign push_s    = in_valid && !full_s;
    assign busy      = (state_q != ST_IDLE) || (count_s != {CW{1'b0}});
    assign f_data_en = f_data_en_q;
    assign f_data    = f_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    iir_feed_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .push_i      (push_s),
        .push_data_i (in_data),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Sequencer next state: issue, latency wait, result hand-off and gap.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        lat_d       = lat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        f_data_en_d = 1'b0;
        f_data_d    = {DW{1'b0}};
        pop_s       = 1'b0;
        if (clear) begin
            state_d     = ST_IDLE;
            gap_d       = {GAP_W{1'b0}};
            lat_d       = {LAT_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gap_q != {GAP_W{1'b0}}) begin
                        gap_d = gap_q - GAP_ONE;
                    end else if (!empty_s) begin
                        // Pulse and data are registered, so they appear in ISSUE.
                        state_d     = ST_ISSUE;
                        f_data_en_d = 1'b1;
                        f_data_d    = head_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    pop_s   = 1'b1;
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_q == {LAT_W{1'b0}}) begin
                        out_valid_d = 1'b1;
                        out_data_d  = f_result;
                        state_d     = ST_OUT;
                    end else begin
                        lat_d = lat_q - LAT_ONE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        gap_d       = gap_cfg;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Sequencer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= {GAP_W{1'b0}};
            lat_q       <= {LAT_W{1'b0}};
            f_data_en_q <= 1'b0;
            f_data_q    <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {RW{1'b0}};
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            lat_q       <= lat_d;
            f_data_en_q <= f_data_en_d;
            f_data_q    <= f_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
